// File: rtl/serial_pkg.sv
// serial_pkg: frame FSM states and default frame geometry shared by serial_tx and a future serial_rx
package serial_pkg;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/baud_tick.sv
// baud_tick: bit-period divider, tick high on the last cycle of each bit period
module baud_tick import serial_pkg::*; #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign cnt_d = (clear || tick) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-in serial transmitter, start bit, DATA_W bits LSB-first, stop bit
module serial_tx import serial_pkg::*; #(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              tick;
    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (tick)
    );
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        done    = 1'b0;
        case (state_q)
            IDLE:  if (load) begin
                state_d = START;
                shift_d = din;
                bit_d   = '0;
            end
            START: if (tick) state_d = DATA;
            DATA:  if (tick) begin
                shift_d = shift_q >> 1;
                if (bit_q == BW'(DATA_W - 1)) state_d = STOP;
                else                          bit_d   = bit_q + BW'(1);
            end
            STOP:  if (tick) begin
                state_d = IDLE;
                done    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // tx is registered from the next state so each bit appears exactly on its first cycle
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    assign ready = state_q == IDLE;
    assign busy  = !ready;
    assign tx    = tx_q;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized self-checking bench for serial_tx against a frame-level line model
module tb_serial_tx;
    localparam int C = 4;
    localparam int N = 10 * C;
    localparam logic [N-1:0] DONE_EXP = {1'b1, {(N-1){1'b0}}};
    logic       clk, rst, load, ready, tx, busy, done;
    logic [7:0] din;
    int         checks, fails;
    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .load  (load),
        .ready (ready),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [N-1:0] wave(input logic [7:0] w);
        logic [9:0] bits;
        bits = {1'b1, w, 1'b0};
        for (int k = 0; k < N; k++) wave[k] = bits[k / C];
    endfunction
    task automatic kick(input logic [7:0] w);
        @(negedge clk);
        din  = w;
        load = 1'b1;
    endtask
    task automatic capture(input int n, input int load_at, input bit scramble, input bit hold,
                           output logic [N-1:0] line, output logic [N-1:0] dn);
        line = '0;
        dn   = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            line[k] = tx;
            dn[k]   = done;
            load    = hold || (k == load_at);
            if (k == load_at) din = 8'hFF;
            if (scramble) din = 8'($urandom);
        end
    endtask
    task automatic test_reset;
        rst  = 1'b1;
        #2;
        checks += 4;
        if (tx !== 1'b1)    begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
        if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready); end
        if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)  begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_single_frame;
        logic [N-1:0] line, dn, exp;
        logic [9:0]   seq;
        seq = 10'h34A;
        for (int k = 0; k < N; k++) exp[k] = seq[k / C];
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b expected 1", ready); end
        din  = 8'hA5;
        load = 1'b1;
        capture(N, -1, 0, 0, line, dn);
        checks += 2;
        if (line !== exp)     begin fails++; $display("FAIL single_line: got %h expected %h", line, exp); end
        if (dn !== DONE_EXP)  begin fails++; $display("FAIL single_done: got %h expected %h", dn, DONE_EXP); end
        @(negedge clk);
        checks++;
        if ({tx, ready, busy, done} !== 4'b1100)
            begin fails++; $display("FAIL single_idle: got %b expected 1100", {tx, ready, busy, done}); end
    endtask
    task automatic test_load_ignored;
        logic [N-1:0] line, dn;
        int           busy_cnt;
        kick(8'h3C);
        capture(N, 9, 0, 0, line, dn);
        checks += 2;
        if (line !== wave(8'h3C)) begin fails++; $display("FAIL ignore_line: got %h expected %h", line, wave(8'h3C)); end
        if (dn !== DONE_EXP)      begin fails++; $display("FAIL ignore_done: got %h expected %h", dn, DONE_EXP); end
        busy_cnt = 0;
        for (int k = 0; k < N + 5; k++) begin
            @(negedge clk);
            busy_cnt += int'(busy) + int'(done);
        end
        checks++;
        if (busy_cnt !== 0) begin fails++; $display("FAIL ignore_queued: got %0d busy/done cycles expected 0", busy_cnt); end
    endtask
    task automatic test_back_to_back;
        logic [N-1:0] line, dn;
        kick(8'h00);
        @(posedge clk);
        #1 din = 8'hFF;
        capture(N, -1, 0, 1, line, dn);
        checks += 2;
        if (line !== wave(8'h00)) begin fails++; $display("FAIL b2b_line0: got %h expected %h", line, wave(8'h00)); end
        if (dn !== DONE_EXP)      begin fails++; $display("FAIL b2b_done0: got %h expected %h", dn, DONE_EXP); end
        @(negedge clk);
        checks++;
        if ({tx, ready, busy} !== 3'b110)
            begin fails++; $display("FAIL b2b_gap: got %b expected 110", {tx, ready, busy}); end
        capture(N, -1, 0, 0, line, dn);
        checks += 2;
        if (line !== wave(8'hFF)) begin fails++; $display("FAIL b2b_line1: got %h expected %h", line, wave(8'hFF)); end
        if (dn !== DONE_EXP)      begin fails++; $display("FAIL b2b_done1: got %h expected %h", dn, DONE_EXP); end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin fails++; $display("FAIL b2b_end_ready: got %b expected 1", ready); end
    endtask
    task automatic test_reset_mid_frame;
        logic [N-1:0] line, dn;
        kick(8'h00);
        capture(15, -1, 0, 0, line, dn);
        checks += 2;
        if (line[14] !== 1'b0) begin fails++; $display("FAIL midrst_pre_tx: got %b expected 0", line[14]); end
        if (dn !== '0)         begin fails++; $display("FAIL midrst_pre_done: got %h expected 0", dn); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tx, ready, busy, done} !== 4'b1100)
            begin fails++; $display("FAIL midrst_async: got %b expected 1100", {tx, ready, busy, done}); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({tx, done} !== 2'b10) begin fails++; $display("FAIL midrst_hold: got %b expected 10", {tx, done}); end
        end
        rst  = 1'b0;
        din  = 8'h5A;
        load = 1'b1;
        capture(N, -1, 0, 0, line, dn);
        checks += 2;
        if (line !== wave(8'h5A)) begin fails++; $display("FAIL midrst_line: got %h expected %h", line, wave(8'h5A)); end
        if (dn !== DONE_EXP)      begin fails++; $display("FAIL midrst_done: got %h expected %h", dn, DONE_EXP); end
        @(negedge clk);
    endtask
    task automatic test_din_stability;
        logic [N-1:0] line, dn;
        kick(8'h81);
        capture(N, -1, 1, 0, line, dn);
        checks += 2;
        if (line !== wave(8'h81)) begin fails++; $display("FAIL stable_line: got %h expected %h", line, wave(8'h81)); end
        if (dn !== DONE_EXP)      begin fails++; $display("FAIL stable_done: got %h expected %h", dn, DONE_EXP); end
        load = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_random;
        logic [N-1:0] line, dn;
        logic [7:0]   w;
        int           gap, idle_bad;
        for (int i = 0; i < 12; i++) begin
            gap      = int'($urandom_range(0, 3));
            idle_bad = 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                idle_bad += int'(tx !== 1'b1) + int'(ready !== 1'b1);
            end
            checks++;
            if (idle_bad !== 0) begin fails++; $display("FAIL rand_idle[%0d]: got %0d bad cycles expected 0", i, idle_bad); end
            w = 8'($urandom);
            kick(w);
            capture(N, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 38)) : -1,
                    $urandom_range(0, 1) != 0, 0, line, dn);
            load = 1'b0;
            checks += 2;
            if (line !== wave(w)) begin fails++; $display("FAIL rand_line[%0d]: got %h expected %h", i, line, wave(w)); end
            if (dn !== DONE_EXP)  begin fails++; $display("FAIL rand_done[%0d]: got %h expected %h", i, dn, DONE_EXP); end
        end
    endtask
    initial begin
        checks = 0;
        fails  = 0;
        load   = 1'b0;
        din    = 8'h00;
        test_reset;
        test_single_frame;
        test_load_ignored;
        test_back_to_back;
        test_reset_mid_frame;
        test_din_stability;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning number of payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port din  input  DATA_W  parallel word to transmit.
REQ-006 SHALL have port load  input  1  request to start a frame with din.
REQ-007 SHALL have port ready  output  1  high when a load is accepted this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-012 SHALL assert ready only in IDLE; busy = not IDLE; tx SHALL be registered, with no combinational path from din/load.
REQ-013 SHALL accept a word on the rising edge where load=1 and ready=1: capture din into the shift register, clear the divider and bit counter, go to START.
REQ-014 SHALL drive tx=0 for exactly CLKS_PER_BIT cycles in START, beginning the cycle after acceptance.
REQ-015 SHALL drive DATA_W bits LSB-first in DATA, each held exactly CLKS_PER_BIT cycles.
REQ-016 SHALL drive tx=1 for exactly CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-017 SHALL pulse done for one cycle on the last STOP cycle; ready SHALL be high the next cycle.
REQ-018 SHALL take exactly (DATA_W+2)*CLKS_PER_BIT cycles from the first START cycle to the first IDLE cycle.
REQ-019 SHALL ignore load while not in IDLE (no queuing, no frame corruption).
REQ-020 SHALL ignore din changes after acceptance; the transmitted data is the captured word.
REQ-021 SHALL allow back-to-back frames: load held high at frame end starts the next START one cycle after re-entering IDLE, with tx high for at least that one idle cycle.
REQ-022 SHALL size the divider counter as clog2(CLKS_PER_BIT) bits and the bit counter as clog2(DATA_W) bits, with no wrap beyond terminal counts.

Reset
REQ-023 SHALL on rst=1, immediately and independent of clk, force state=IDLE, tx=1, ready=1, busy=0, done=0, and shift register, divider and bit counter to 0.
REQ-024 SHALL abort a frame when rst asserts mid-frame: no done pulse, tx high at once, and no partial frame resumed after release.
REQ-025 SHALL accept load on the first rising edge after rst deasserts.

Structure
REQ-026 SHALL place the state enumeration and the default DATA_W/CLKS_PER_BIT constants in shared package serial_pkg, for reuse by a future serial_rx.
REQ-027 SHALL place the bit-period divider in one sub-module, baud_tick: inputs clk, rst, clear; output tick, high on the last cycle of each bit period.
REQ-028 SHALL keep the FSM, shift register and bit counter in serial_tx.

Verification
REQ-029 SHALL verify reset: rst pulse mid-cycle -> tx=1, ready=1, busy=0 before the next clk edge.
REQ-030 SHALL verify a single frame: CLKS_PER_BIT=4, din=8'hA5, one-cycle load -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; done after 40 cycles.
REQ-031 SHALL verify load ignored while busy: din=8'h3C accepted, then load with din=8'hFF at cycle 10 -> line still carries 8'h3C, exactly one done.
REQ-032 SHALL verify back-to-back frames: load held high with din=8'h00 then 8'hFF -> two 40-cycle frames separated by exactly one idle cycle with tx=1.
REQ-033 SHALL verify reset mid-frame: rst at cycle 15 of a frame -> tx=1 immediately, no done; a new load after release sends a complete correct frame.
REQ-034 SHALL verify din stability: din changes every cycle after acceptance of 8'h81 -> line carries 8'h81.
